// File: rtl/demultiplexor_buffered_pkg.sv
// Shared types for the buffered demultiplexor: the occupancy states of a
// two-entry lane FIFO. Lane count and word widths stay module parameters.
package demultiplexor_buffered_pkg;

    // Occupancy of one lane FIFO; the encoding equals the word count.
    typedef enum logic [1:0] {
        LANE_EMPTY = 2'd0,
        LANE_ONE   = 2'd1,
        LANE_TWO   = 2'd2
    } lane_state_e;

    // True when a lane in state s can take another word.
    function automatic logic lane_has_room(input lane_state_e s);
        return (s != LANE_TWO);
    endfunction

endpackage

// File: rtl/lane_fifo2.sv
// Two-entry FIFO for one demultiplexor output lane.
//
// state      | meaning
// -----------+------------------------------------------------
// LANE_EMPTY | no word held, HeadValid low
// LANE_ONE   | one word in the head slot
// LANE_TWO   | head and tail slots both hold words, Full high
//
// The head slot is a register wired straight to HeadData, so the consumer
// never sees a mux path from the input. A push into a one-word lane that is
// popped in the same cycle overwrites the head directly.
module lane_fifo2
    import demultiplexor_buffered_pkg::*;
#(
    parameter int bDATA = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [bDATA-1:0] PushData,
    input  logic             Push,
    input  logic             Pop,
    output logic [bDATA-1:0] HeadData,
    output logic             HeadValid,
    output logic             Full
);

    lane_state_e      state;
    lane_state_e      state_next;
    logic [bDATA-1:0] head;
    logic [bDATA-1:0] head_next;
    logic [bDATA-1:0] tail;
    logic [bDATA-1:0] tail_next;
    logic             push_eff;
    logic             pop_eff;

    // Next occupancy and slot contents from the push/pop pair.
    always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        push_eff   = Push & lane_has_room(state);
        pop_eff    = Pop & (state != LANE_EMPTY);
        case (state)
            LANE_EMPTY: begin
                if (push_eff) begin
                    state_next = LANE_ONE;
                    head_next  = PushData;
                end
            end
            LANE_ONE: begin
                case ({push_eff, pop_eff})
                    2'b10: begin
                        state_next = LANE_TWO;
                        tail_next  = PushData;
                    end
                    2'b01: begin
                        state_next = LANE_EMPTY;
                    end
                    2'b11: begin
                        head_next  = PushData;
                    end
                    default: begin
                        state_next = LANE_ONE;
                    end
                endcase
            end
            LANE_TWO: begin
                if (pop_eff) begin
                    state_next = LANE_ONE;
                    head_next  = tail;
                end
            end
            default: begin
                state_next = LANE_EMPTY;
            end
        endcase
    end

    // State and slot registers; reset discards everything held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LANE_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
        end
    end

    assign HeadData  = head;
    assign HeadValid = (state != LANE_EMPTY);
    assign Full      = (state == LANE_TWO);

endmodule

// File: rtl/demultiplexor_buffered.sv
// Buffered 1-to-N stream demultiplexor. Each input word is steered to the
// lane named by InSelect and queued in that lane's two-entry FIFO, so a
// stalled consumer only blocks words addressed to its own lane. Words with
// a select beyond the last lane are accepted, discarded and flagged.
module demultiplexor_buffered #(
    parameter int nOUTPUT = 4,
    parameter int bDATA   = 4,
    parameter int bSEL    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [bDATA-1:0]         InData,
    input  logic [bSEL-1:0]          InSelect,
    input  logic                     InValid,
    output logic                     InReady,
    output logic [bDATA*nOUTPUT-1:0] OutData,
    output logic [nOUTPUT-1:0]       OutValid,
    input  logic [nOUTPUT-1:0]       OutReady,
    output logic                     Dropped
);

    logic [nOUTPUT-1:0] lane_hit;
    logic [nOUTPUT-1:0] lane_full;
    logic [nOUTPUT-1:0] lane_push;
    logic               sel_ok;
    logic               accept;
    logic               dropped_q;

    // One-hot decode of the select; an out-of-range select hits no lane.
    always_comb begin
        lane_hit = '0;
        for (int i = 0; i < nOUTPUT; i++) begin
            lane_hit[i] = (InSelect == bSEL'(i));
        end
    end

    // Ready depends only on the select and registered fullness, never on OutReady.
    always_comb begin
        sel_ok    = |lane_hit;
        InReady   = ~sel_ok | ~(|(lane_hit & lane_full));
        accept    = InValid & InReady;
        lane_push = {nOUTPUT{accept}} & lane_hit;
    end

    for (genvar g = 0; g < nOUTPUT; g++) begin : g_lane
        lane_fifo2 #(
            .bDATA (bDATA)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .PushData  (InData),
            .Push      (lane_push[g]),
            .Pop       (OutReady[g]),
            .HeadData  (OutData[g*bDATA +: bDATA]),
            .HeadValid (OutValid[g]),
            .Full      (lane_full[g])
        );
    end

    // Pulse the cycle after an accepted word was discarded for a bad select.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= accept & ~sel_ok;
        end
    end

    assign Dropped = dropped_q;

endmodule

// File: tb/tb_demultiplexor_buffered.sv
// Scoreboard bench for demultiplexor_buffered with three lanes and a 2-bit
// select, so select value 3 exercises the discard path.
module tb_demultiplexor_buffered;

    localparam int NL = 3;
    localparam int BD = 4;
    localparam int BS = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [BD-1:0]     InData = '0;
    logic [BS-1:0]     InSelect = '0;
    logic              InValid = 1'b0;
    logic              InReady;
    logic [BD*NL-1:0]  OutData;
    logic [NL-1:0]     OutValid;
    logic [NL-1:0]     OutReady = '0;
    logic              Dropped;

    int total = 0;
    int bad = 0;

    logic [BD-1:0] q [NL][$];
    logic          exp_dropped = 1'b0;
    logic          mon_en = 1'b0;

    demultiplexor_buffered #(
        .nOUTPUT (NL),
        .bDATA   (BD),
        .bSEL    (BS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .InData   (InData),
        .InSelect (InSelect),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Dropped  (Dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at +1, check ready at +3, commit to model at +7.
    task automatic step(input logic v, input logic [BS-1:0] s, input logic [BD-1:0] d,
                        input logic [NL-1:0] r, input logic rst);
        logic acc;
        logic exp_rdy;
        @(posedge clk);
        #1;
        InValid  = v;
        InSelect = s;
        InData   = d;
        OutReady = r;
        reset    = rst;
        #2;
        acc = 1'b0;
        if (!rst) begin
            if (s == 2'd3) exp_rdy = 1'b1;
            else exp_rdy = (q[s].size() != 2);
            chk("in_ready", int'(InReady), int'(exp_rdy));
            acc = v & InReady;
        end
        #4;
        if (rst) begin
            for (int i = 0; i < NL; i++) q[i].delete();
            exp_dropped = 1'b0;
        end else begin
            exp_dropped = acc && (s == 2'd3);
            if (acc && s != 2'd3) q[s].push_back(d);
        end
    endtask

    // Monitor: compares lane outputs with the model heads and retires pops.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NL; i++) begin
                chk($sformatf("valid%0d", i), int'(OutValid[i]), int'(q[i].size() != 0));
                if (q[i].size() != 0) begin
                    chk($sformatf("head%0d", i), int'(OutData[i*BD +: BD]), int'(q[i][0]));
                    if (OutReady[i] && !reset) void'(q[i].pop_front());
                end
            end
            chk("dropped", int'(Dropped), int'(exp_dropped));
        end
    end

    initial begin
        step(1'b0, 2'd0, 4'h0, 3'b111, 1'b1);
        step(1'b0, 2'd0, 4'h0, 3'b111, 1'b1);
        step(1'b0, 2'd0, 4'h0, 3'b111, 1'b0);
        chk("rst_outdata", int'(OutData), 0);
        chk("rst_outvalid", int'(OutValid), 0);
        chk("rst_inready", int'(InReady), 1);
        chk("rst_dropped", int'(Dropped), 0);
        mon_en = 1'b1;

        // streaming into lane 2
        step(1'b1, 2'd2, 4'h3, 3'b111, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b111, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b111, 1'b0);

        // fill lane 1 behind a stalled consumer, lane 0 still flows
        step(1'b1, 2'd1, 4'hA, 3'b101, 1'b0);
        step(1'b1, 2'd1, 4'hB, 3'b101, 1'b0);
        step(1'b1, 2'd1, 4'hC, 3'b101, 1'b0);
        chk("full_blocks", int'(InReady), 0);
        step(1'b1, 2'd0, 4'h5, 3'b100, 1'b0);
        step(1'b1, 2'd1, 4'hC, 3'b111, 1'b0);
        step(1'b1, 2'd1, 4'hC, 3'b111, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b111, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b111, 1'b0);

        // push and pop together on a one-word lane
        step(1'b1, 2'd0, 4'h6, 3'b000, 1'b0);
        step(1'b1, 2'd0, 4'h9, 3'b001, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b000, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b001, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b001, 1'b0);

        // out-of-range select
        step(1'b1, 2'd3, 4'hF, 3'b000, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b000, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b000, 1'b0);

        // reset with lanes full
        step(1'b1, 2'd0, 4'h1, 3'b000, 1'b0);
        step(1'b1, 2'd0, 4'h2, 3'b000, 1'b0);
        step(1'b1, 2'd1, 4'h3, 3'b000, 1'b0);
        step(1'b1, 2'd1, 4'h4, 3'b000, 1'b0);
        step(1'b1, 2'd0, 4'h7, 3'b011, 1'b1);
        step(1'b1, 2'd2, 4'h4, 3'b000, 1'b0);
        chk("post_rst_valid", int'(OutValid), 0);
        step(1'b0, 2'd0, 4'h0, 3'b000, 1'b0);
        step(1'b0, 2'd0, 4'h0, 3'b111, 1'b0);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 3) != 0), BS'($urandom_range(0, 3)), BD'($urandom),
                 NL'($urandom), ($urandom_range(0, 199) == 0));
        end

        for (int n = 0; n < 6; n++) step(1'b0, 2'd0, 4'h0, 3'b111, 1'b0);
        chk("drain_ready", int'(InReady), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
